// File: rtl/adxl362_registers_pkg.sv
// Shared address map, ID constants and sample record for the ADXL362 register bank model.
// Also provides the write-mask helper for the partially writable R/W registers.
package adxl362_pkg;

  localparam logic [5:0] ADDR_DEVID_AD      = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST     = 6'h01;
  localparam logic [5:0] ADDR_PARTID        = 6'h02;
  localparam logic [5:0] ADDR_REVID         = 6'h03;
  localparam logic [5:0] ADDR_XDATA         = 6'h08;
  localparam logic [5:0] ADDR_YDATA         = 6'h09;
  localparam logic [5:0] ADDR_ZDATA         = 6'h0A;
  localparam logic [5:0] ADDR_STATUS        = 6'h0B;
  localparam logic [5:0] ADDR_FIFO_ENT_L    = 6'h0C;
  localparam logic [5:0] ADDR_FIFO_ENT_H    = 6'h0D;
  localparam logic [5:0] ADDR_XDATA_L       = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H       = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L       = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H       = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L       = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H       = 6'h13;
  localparam logic [5:0] ADDR_TEMP_L        = 6'h14;
  localparam logic [5:0] ADDR_TEMP_H        = 6'h15;
  localparam logic [5:0] ADDR_SOFT_RESET    = 6'h1F;
  localparam logic [5:0] ADDR_THRESH_ACT_L  = 6'h20;
  localparam logic [5:0] ADDR_THRESH_ACT_H  = 6'h21;
  localparam logic [5:0] ADDR_TIME_ACT      = 6'h22;
  localparam logic [5:0] ADDR_THRESH_INACT_L = 6'h23;
  localparam logic [5:0] ADDR_THRESH_INACT_H = 6'h24;
  localparam logic [5:0] ADDR_TIME_INACT_L  = 6'h25;
  localparam logic [5:0] ADDR_TIME_INACT_H  = 6'h26;
  localparam logic [5:0] ADDR_ACT_INACT_CTL = 6'h27;
  localparam logic [5:0] ADDR_FIFO_CONTROL  = 6'h28;
  localparam logic [5:0] ADDR_FIFO_SAMPLES  = 6'h29;
  localparam logic [5:0] ADDR_INTMAP1       = 6'h2A;
  localparam logic [5:0] ADDR_INTMAP2       = 6'h2B;
  localparam logic [5:0] ADDR_FILTER_CTL    = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL     = 6'h2D;
  localparam logic [5:0] ADDR_SELF_TEST     = 6'h2E;

  localparam logic [7:0] DEVID_AD  = 8'hAD;
  localparam logic [7:0] DEVID_MST = 8'h1D;
  localparam logic [7:0] PARTID    = 8'hF2;

  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [1:0] MEASURE_MODE   = 2'b10;

  localparam int STATUS_DATA_READY = 0;
  localparam int STATUS_AWAKE      = 6;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [11:0] z;
    logic signed [11:0] t;
  } sample_set_t;

  function automatic logic [7:0] rw_mask(input logic [5:0] addr);
    case (addr)
      ADDR_THRESH_ACT_H, ADDR_THRESH_INACT_H: rw_mask = 8'h07;
      ADDR_SELF_TEST:                         rw_mask = 8'h01;
      default:                                rw_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/adxl362_registers_if.sv
// Clock-domain register bus between the SPI block (master) and the register bank (slave).
interface adxl362_registers_if;
  logic [5:0] address;
  logic [7:0] data_write;
  logic       write;
  logic       read;
  logic [7:0] data_read;

  modport master (output address, output data_write, output write, output read, input data_read);
  modport slave  (input address, input data_write, input write, input read, output data_read);
endinterface

// File: rtl/adxl362_registers_int_map.sv
// One interrupt pin: masks DATA_READY with an INTMAP byte, applies polarity, registers the level.
module adxl362_int_map (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_intmap,
  input  logic       i_data_ready,
  output logic       o_int
);

  logic w_raw;
  logic r_int;

  assign w_raw = |(i_intmap[6:0] & {6'b0, i_data_ready});
  assign o_int = r_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_int <= 1'b0;
    else        r_int <= w_raw ^ i_intmap[7];
  end

endmodule

// File: rtl/adxl362_registers.sv
// ADXL362 model register bank: ID/config/status/data registers with coherent 16-bit reads.
// Optional SOFT_RESET register at 0x1F enabled by defining ADXL362_SOFT_RESET_EN.
module adxl362_registers
  import adxl362_pkg::*;
#(
  parameter logic [7:0] REVID          = 8'h01,
  parameter logic [7:0] FILTER_CTL_RST = 8'h13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adxl362_registers_if.slave        bus,
  input  logic                      sample_valid,
  input  logic signed [11:0]        x_sample,
  input  logic signed [11:0]        y_sample,
  input  logic signed [11:0]        z_sample,
  input  logic signed [11:0]        temp_sample,
  output logic                      int1,
  output logic                      int2
);

  logic [7:0]  r_rw [15];
  sample_set_t r_data;
  sample_set_t r_snap;
  logic        r_data_ready;
  logic [7:0]  r_data_read;

  logic        w_in_rw;
  logic [3:0]  w_rw_idx;
  logic        w_awake;
  logic        w_accept;
  logic        w_data_rd;
  logic        w_lo_rd;
  logic        w_soft_rst;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_val;

  function automatic logic [7:0] rw_rst(input int idx);
    rw_rst = (idx == int'(ADDR_FILTER_CTL[3:0])) ? FILTER_CTL_RST : 8'h00;
  endfunction

  function automatic logic [7:0] hi_byte(input logic signed [11:0] v);
    hi_byte = {{4{v[11]}}, v[11:8]};
  endfunction

  // R/W block starts on a 16-byte boundary, so the low nibble is the array index
  assign w_in_rw   = (bus.address >= ADDR_THRESH_ACT_L) && (bus.address <= ADDR_SELF_TEST);
  assign w_rw_idx  = bus.address[3:0];
  assign w_awake   = (r_rw[ADDR_POWER_CTL[3:0]][1:0] == MEASURE_MODE);
  assign w_accept  = sample_valid && w_awake;
  assign w_data_rd = bus.read && (bus.address >= ADDR_XDATA) && (bus.address <= ADDR_TEMP_H);
  assign w_lo_rd   = bus.read && ((bus.address == ADDR_XDATA_L) || (bus.address == ADDR_YDATA_L) ||
                                  (bus.address == ADDR_ZDATA_L) || (bus.address == ADDR_TEMP_L));
  assign w_status  = 8'(r_data_ready) << STATUS_DATA_READY | 8'(w_awake) << STATUS_AWAKE;

`ifdef ADXL362_SOFT_RESET_EN
  assign w_soft_rst = bus.write && (bus.address == ADDR_SOFT_RESET) && (bus.data_write == SOFT_RESET_KEY);
`else
  assign w_soft_rst = 1'b0;
`endif

  always_comb begin
    w_rd_val = 8'h00;
    if (w_in_rw) begin
      w_rd_val = r_rw[w_rw_idx];
    end else begin
      case (bus.address)
        ADDR_DEVID_AD:  w_rd_val = DEVID_AD;
        ADDR_DEVID_MST: w_rd_val = DEVID_MST;
        ADDR_PARTID:    w_rd_val = PARTID;
        ADDR_REVID:     w_rd_val = REVID;
        ADDR_XDATA:     w_rd_val = r_data.x[11:4];
        ADDR_YDATA:     w_rd_val = r_data.y[11:4];
        ADDR_ZDATA:     w_rd_val = r_data.z[11:4];
        ADDR_STATUS:    w_rd_val = w_status;
        // low bytes come from live data, high bytes from the snapshot taken by the low-byte read
        ADDR_XDATA_L:   w_rd_val = r_data.x[7:0];
        ADDR_XDATA_H:   w_rd_val = hi_byte(r_snap.x);
        ADDR_YDATA_L:   w_rd_val = r_data.y[7:0];
        ADDR_YDATA_H:   w_rd_val = hi_byte(r_snap.y);
        ADDR_ZDATA_L:   w_rd_val = r_data.z[7:0];
        ADDR_ZDATA_H:   w_rd_val = hi_byte(r_snap.z);
        ADDR_TEMP_L:    w_rd_val = r_data.t[7:0];
        ADDR_TEMP_H:    w_rd_val = hi_byte(r_snap.t);
        default:        w_rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_rw[i] <= rw_rst(i);
      r_data       <= '0;
      r_snap       <= '0;
      r_data_ready <= 1'b0;
    end else if (w_soft_rst) begin
      for (int i = 0; i < 15; i++) r_rw[i] <= rw_rst(i);
      r_data       <= '0;
      r_snap       <= '0;
      r_data_ready <= 1'b0;
    end else begin
      if (bus.write && w_in_rw) r_rw[w_rw_idx] <= bus.data_write & rw_mask(bus.address);
      if (w_accept) r_data <= '{x: x_sample, y: y_sample, z: z_sample, t: temp_sample};
      if (w_lo_rd)  r_snap <= r_data;
      // a sample landing on the same edge as a data read keeps DATA_READY set
      if (w_accept)       r_data_ready <= 1'b1;
      else if (w_data_rd) r_data_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_data_read <= 8'h00;
    else if (bus.read && !w_soft_rst) r_data_read <= w_rd_val;
  end

  assign bus.data_read = r_data_read;

  adxl362_int_map u_int1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_intmap     (r_rw[ADDR_INTMAP1[3:0]]),
    .i_data_ready (r_data_ready),
    .o_int        (int1)
  );

  adxl362_int_map u_int2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_intmap     (r_rw[ADDR_INTMAP2[3:0]]),
    .i_data_ready (r_data_ready),
    .o_int        (int2)
  );

endmodule

// File: tb/tb_adxl362_registers.sv
// Directed, table-driven bench for adxl362_registers; follows ADXL362_SOFT_RESET_EN if defined.
module tb_adxl362_registers;

  logic               clk;
  logic               rst_n;
  logic               sample_valid;
  logic signed [11:0] x_sample, y_sample, z_sample, temp_sample;
  logic               int1, int2;
  int                 checks;
  int                 failures;

  adxl362_registers_if bus ();

  adxl362_registers dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sample_valid (sample_valid),
    .x_sample     (x_sample),
    .y_sample     (y_sample),
    .z_sample     (z_sample),
    .temp_sample  (temp_sample),
    .int1         (int1),
    .int2         (int2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr, rd, sv;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [11:0] xs;
    logic       crd;
    logic [7:0] erd;
    logic       ci1, ei1, ci2, ei2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic rd, logic sv, logic [5:0] a, logic [7:0] d,
                              logic [11:0] x, logic crd, logic [7:0] e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sv = sv; v.addr = a; v.wd = d; v.xs = x;
    v.crd = crd; v.erd = e; v.ci1 = 1'b0; v.ei1 = 1'b0; v.ci2 = 1'b0; v.ei2 = 1'b0;
    return v;
  endfunction

  function automatic vec_t f_rd(logic [5:0] a, logic [7:0] e);
    return mk(1'b0, 1'b1, 1'b0, a, 8'h00, 12'h000, 1'b1, e);
  endfunction
  function automatic vec_t f_wr(logic [5:0] a, logic [7:0] d);
    return mk(1'b1, 1'b0, 1'b0, a, d, 12'h000, 1'b0, 8'h00);
  endfunction
  function automatic vec_t f_sv(logic [11:0] x);
    return mk(1'b0, 1'b0, 1'b1, 6'h00, 8'h00, x, 1'b0, 8'h00);
  endfunction
  function automatic vec_t f_idle();
    return mk(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 12'h000, 1'b0, 8'h00);
  endfunction
  function automatic vec_t i1(vec_t v, logic e);
    vec_t r = v;
    r.ci1 = 1'b1; r.ei1 = e;
    return r;
  endfunction
  function automatic vec_t i2(vec_t v, logic e);
    vec_t r = v;
    r.ci2 = 1'b1; r.ei2 = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, let the rising edge act, then sample at the next falling edge.
  task automatic apply(input vec_t v, input string nm);
    bus.write      = v.wr;
    bus.read       = v.rd;
    bus.address    = v.addr;
    bus.data_write = v.wd;
    sample_valid   = v.sv;
    if (v.sv) x_sample = v.xs;
    @(posedge clk);
    @(negedge clk);
    bus.write    = 1'b0;
    bus.read     = 1'b0;
    sample_valid = 1'b0;
    if (v.crd) check({nm, "_rd"}, bus.data_read, v.erd);
    if (v.ci1) check({nm, "_int1"}, {7'b0, int1}, {7'b0, v.ei1});
    if (v.ci2) check({nm, "_int2"}, {7'b0, int2}, {7'b0, v.ei2});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.write = 1'b0; bus.read = 1'b0; bus.address = 6'h00; bus.data_write = 8'h00;
    sample_valid = 1'b0;
    x_sample = 12'h000; y_sample = 12'h800; z_sample = 12'h001; temp_sample = 12'h7F0;
    repeat (2) @(negedge clk);
    check("rst_data_read", bus.data_read, 8'h00);
    check("rst_int1", {7'b0, int1}, 8'h00);
    check("rst_int2", {7'b0, int2}, 8'h00);
    rst_n = 1'b1;

    // IDs, reset values, dropped sample with measurement off
    tbl.push_back(f_rd(6'h00, 8'hAD));
    tbl.push_back(f_rd(6'h01, 8'h1D));
    tbl.push_back(f_rd(6'h02, 8'hF2));
    tbl.push_back(f_rd(6'h03, 8'h01));
    tbl.push_back(f_rd(6'h2C, 8'h13));
    tbl.push_back(f_rd(6'h08, 8'h00));
    tbl.push_back(f_rd(6'h0B, 8'h00));
    tbl.push_back(f_sv(12'h123));
    tbl.push_back(f_rd(6'h08, 8'h00));
    tbl.push_back(f_rd(6'h0B, 8'h00));
    // measurement on, sample, data/status reads
    tbl.push_back(f_wr(6'h2D, 8'h02));
    tbl.push_back(f_sv(12'hF9C));
    tbl.push_back(f_rd(6'h0B, 8'h41));
    tbl.push_back(f_rd(6'h0E, 8'h9C));
    tbl.push_back(f_rd(6'h0F, 8'hFF));
    tbl.push_back(f_rd(6'h0B, 8'h40));
    tbl.push_back(f_rd(6'h08, 8'hF9));
    tbl.push_back(f_rd(6'h09, 8'h80));
    tbl.push_back(f_rd(6'h10, 8'h00));
    tbl.push_back(f_rd(6'h11, 8'hF8));
    tbl.push_back(f_rd(6'h12, 8'h01));
    tbl.push_back(f_rd(6'h13, 8'h00));
    tbl.push_back(f_rd(6'h14, 8'hF0));
    tbl.push_back(f_rd(6'h15, 8'h07));
    tbl.push_back(f_rd(6'h0C, 8'h00));
    tbl.push_back(f_rd(6'h0D, 8'h00));
    // write masks, read-only/unmapped, read+write collision
    tbl.push_back(f_wr(6'h21, 8'hFF));
    tbl.push_back(f_rd(6'h21, 8'h07));
    tbl.push_back(f_wr(6'h24, 8'hFF));
    tbl.push_back(f_rd(6'h24, 8'h07));
    tbl.push_back(f_wr(6'h2E, 8'hFF));
    tbl.push_back(f_rd(6'h2E, 8'h01));
    tbl.push_back(f_wr(6'h00, 8'h55));
    tbl.push_back(f_rd(6'h00, 8'hAD));
    tbl.push_back(f_rd(6'h3F, 8'h00));
    tbl.push_back(f_rd(6'h1F, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 6'h20, 8'hAA, 12'h000, 1'b1, 8'h00));
    tbl.push_back(f_rd(6'h20, 8'hAA));
    tbl.push_back(f_rd(6'h2D, 8'h02));
    // INT1 active-high then inverted, plus high-byte snapshot coherency
    tbl.push_back(i1(f_wr(6'h2A, 8'h01), 1'b0));
    tbl.push_back(i1(f_sv(12'h010), 1'b0));
    tbl.push_back(i1(f_idle(), 1'b1));
    tbl.push_back(i1(f_rd(6'h0E, 8'h10), 1'b1));
    tbl.push_back(i1(f_idle(), 1'b0));
    tbl.push_back(i1(f_wr(6'h2A, 8'h81), 1'b0));
    tbl.push_back(i1(f_idle(), 1'b1));
    tbl.push_back(i1(f_sv(12'h7FF), 1'b1));
    tbl.push_back(i1(f_idle(), 1'b0));
    tbl.push_back(i1(f_rd(6'h0F, 8'h00), 1'b0));
    tbl.push_back(i1(f_idle(), 1'b1));
    tbl.push_back(f_rd(6'h0E, 8'hFF));
    tbl.push_back(f_rd(6'h0F, 8'h07));
    tbl.push_back(f_rd(6'h08, 8'h7F));
    // data read coinciding with an accepted sample
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 6'h0B, 8'h00, 12'h020, 1'b1, 8'h40));
    tbl.push_back(f_rd(6'h0B, 8'h41));
    tbl.push_back(f_rd(6'h0B, 8'h40));
    tbl.push_back(f_rd(6'h0E, 8'h20));
    // INT2 polarity only
    tbl.push_back(i2(f_wr(6'h2B, 8'h80), 1'b0));
    tbl.push_back(i2(f_idle(), 1'b1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // soft reset key handling
    apply(f_wr(6'h20, 8'h55), "sr_wr20");
    apply(f_wr(6'h1F, 8'h51), "sr_badkey");
    apply(f_rd(6'h20, 8'h55), "sr_badkey_20");
    apply(f_rd(6'h2B, 8'h80), "sr_badkey_2b");
    apply(i2(f_wr(6'h1F, 8'h52), 1'b1), "sr_key");
    check("sr_data_read_hold", bus.data_read, 8'h80);
`ifdef ADXL362_SOFT_RESET_EN
    apply(i2(f_idle(), 1'b0), "sr_int2_follow");
    apply(f_rd(6'h20, 8'h00), "sr_20");
    apply(f_rd(6'h2C, 8'h13), "sr_2c");
    apply(f_rd(6'h2D, 8'h00), "sr_2d");
    apply(f_rd(6'h0B, 8'h00), "sr_status");
    apply(f_rd(6'h0F, 8'h00), "sr_snap");
`else
    apply(i2(f_idle(), 1'b1), "nosr_int2");
    apply(f_rd(6'h20, 8'h55), "nosr_20");
    apply(f_rd(6'h2D, 8'h02), "nosr_2d");
`endif

    // asynchronous reset mid-cycle with live state
    apply(f_wr(6'h2B, 8'h80), "ar_wr2b");
    apply(f_wr(6'h2D, 8'h02), "ar_wr2d");
    apply(f_sv(12'h456), "ar_sv");
    apply(i2(f_rd(6'h2D, 8'h02), 1'b1), "ar_pre");
    #2 rst_n = 1'b0;
    #1;
    check("ar_data_read", bus.data_read, 8'h00);
    check("ar_int2", {7'b0, int2}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(f_sv(12'h123), "ar_sv_off");
    apply(f_rd(6'h0B, 8'h00), "ar_status");
    apply(f_rd(6'h08, 8'h00), "ar_x");
    apply(f_rd(6'h2D, 8'h00), "ar_2d");
    apply(f_rd(6'h2B, 8'h00), "ar_2b");
    apply(f_rd(6'h2C, 8'h13), "ar_2c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
